// File: rtl/wb2axi_pkg.sv
// Shared definitions for the Wishbone-to-AXI bridges (write and read paths).
// Holds AXI attribute encodings, bridge FSM state encodings and a size helper.
// Pure package: no logic, no latency, no flow control.
package wb2axi_pkg;

  // Bridge FSM states, common to the read and write bridges
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_e;

  // AXI attribute encodings
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
  localparam logic [2:0] AXI_PROT_NONE   = 3'b000;
  localparam logic [3:0] AXI_QOS_NONE    = 4'b0000;
  localparam logic [3:0] AXI_REGION_NONE = 4'b0000;
  localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;

  // AxSIZE encoding for a beat of nbytes bytes (log2 of the byte count)
  function automatic logic [2:0] axi_size(input int unsigned nbytes);
    logic [2:0] sz;
    case (nbytes)
      1:       sz = 3'd0;
      2:       sz = 3'd1;
      4:       sz = 3'd2;
      8:       sz = 3'd3;
      16:      sz = 3'd4;
      default: sz = 3'd0;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/wb2axi_write.sv
// Wishbone write to single-beat AXI4 write bridge, one transaction outstanding.
// Latency: AW/W valid one cycle after capture; wb_ack one cycle after the B handshake.
// Backpressure: AW and W held stable until their own handshake; new captures wait for DONE to clear.
module wb2axi_write
  import wb2axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  // Wishbone side
  input  logic [ADDR_WIDTH-1:0]   wb_adr,
  input  logic [DATA_WIDTH-1:0]   wb_dat,
  input  logic [DATA_WIDTH/8-1:0] wb_sel,
  input  logic                    wb_we,
  input  logic                    wb_cyc,
  input  logic                    i_cnt_done,
  output logic                    wb_ack,
  output logic                    wb_err,
  // AXI write address channel
  output logic [ID_WIDTH-1:0]     M_AXI_awid,
  output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [7:0]              M_AXI_awlen,
  output logic [2:0]              M_AXI_awsize,
  output logic [1:0]              M_AXI_awburst,
  output logic [1:0]              M_AXI_awlock,
  output logic [3:0]              M_AXI_awcache,
  output logic [2:0]              M_AXI_awprot,
  output logic [3:0]              M_AXI_awqos,
  output logic [3:0]              M_AXI_awregion,
  output logic                    M_AXI_awvalid,
  input  logic                    M_AXI_awready,
  // AXI write data channel
  output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                    M_AXI_wlast,
  output logic                    M_AXI_wvalid,
  input  logic                    M_AXI_wready,
  // AXI write response channel
  input  logic [ID_WIDTH-1:0]     M_AXI_bid,
  input  logic [1:0]              M_AXI_bresp,
  input  logic                    M_AXI_bvalid,
  output logic                    M_AXI_bready
);

  bridge_state_e           state_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    awvalid_q, wvalid_q, bready_q;
  logic                    aw_done_q, w_done_q;
  logic                    ack_q, err_q;

  logic aw_hs, w_hs, aw_fin, w_fin, capture;
  logic unused_inputs;

  // Only one ID is ever in flight and only the SLVERR/DECERR bit matters
  assign unused_inputs = ^{M_AXI_bid, M_AXI_bresp[0]};

  assign capture = wb_cyc && wb_we && i_cnt_done;
  assign aw_hs   = awvalid_q && M_AXI_awready;
  assign w_hs    = wvalid_q && M_AXI_wready;
  // A channel is finished if it completed earlier or completes this cycle
  assign aw_fin  = aw_done_q || aw_hs;
  assign w_fin   = w_done_q || w_hs;

  // Single-beat INCR write with fixed attributes
  assign M_AXI_awid     = ID_WIDTH'(AXI_ID);
  assign M_AXI_awlen    = AXI_LEN_SINGLE;
  assign M_AXI_awsize   = axi_size(DATA_WIDTH / 8);
  assign M_AXI_awburst  = AXI_BURST_INCR;
  assign M_AXI_awlock   = AXI_LOCK_NORMAL;
  assign M_AXI_awcache  = AXI_CACHE_NONE;
  assign M_AXI_awprot   = AXI_PROT_NONE;
  assign M_AXI_awqos    = AXI_QOS_NONE;
  assign M_AXI_awregion = AXI_REGION_NONE;

  assign M_AXI_awaddr  = awaddr_q;
  assign M_AXI_awvalid = awvalid_q;
  assign M_AXI_wdata   = wdata_q;
  assign M_AXI_wstrb   = wstrb_q;
  assign M_AXI_wvalid  = wvalid_q;
  assign M_AXI_wlast   = wvalid_q;
  assign M_AXI_bready  = bready_q;
  assign wb_ack        = ack_q;
  assign wb_err        = err_q;

  // Bridge FSM with all handshake outputs registered
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (capture) begin
            awaddr_q  <= wb_adr;
            wdata_q   <= wb_dat;
            wstrb_q   <= wb_sel;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (M_AXI_bvalid) begin
            bready_q <= 1'b0;
            ack_q    <= 1'b1;
            err_q    <= M_AXI_bresp[1];
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Wait for the master to release the request so a held cycle is not reissued
          if (!wb_cyc || !i_cnt_done) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb2axi_write.sv
// Randomized bench for wb2axi_write with a cycle-level reference of the bridge behaviour.
// Each scenario task drives a Wishbone master and AXI slave and checks outputs inline.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_wb2axi_write;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat;
  logic [3:0]    wb_sel;
  logic          wb_we, wb_cyc, i_cnt_done, wb_ack, wb_err;
  logic [IW-1:0] M_AXI_awid;
  logic [AW-1:0] M_AXI_awaddr;
  logic [7:0]    M_AXI_awlen;
  logic [2:0]    M_AXI_awsize, M_AXI_awprot;
  logic [1:0]    M_AXI_awburst, M_AXI_awlock;
  logic [3:0]    M_AXI_awcache, M_AXI_awqos, M_AXI_awregion;
  logic          M_AXI_awvalid, M_AXI_awready;
  logic [DW-1:0] M_AXI_wdata;
  logic [3:0]    M_AXI_wstrb;
  logic          M_AXI_wlast, M_AXI_wvalid, M_AXI_wready;
  logic [IW-1:0] M_AXI_bid;
  logic [1:0]    M_AXI_bresp;
  logic          M_AXI_bvalid, M_AXI_bready;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 ACLK = ~ACLK;

  wb2axi_write #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(5)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .wb_adr(wb_adr), .wb_dat(wb_dat), .wb_sel(wb_sel), .wb_we(wb_we), .wb_cyc(wb_cyc),
    .i_cnt_done(i_cnt_done), .wb_ack(wb_ack), .wb_err(wb_err),
    .M_AXI_awid(M_AXI_awid), .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awlen(M_AXI_awlen),
    .M_AXI_awsize(M_AXI_awsize), .M_AXI_awburst(M_AXI_awburst), .M_AXI_awlock(M_AXI_awlock),
    .M_AXI_awcache(M_AXI_awcache), .M_AXI_awprot(M_AXI_awprot), .M_AXI_awqos(M_AXI_awqos),
    .M_AXI_awregion(M_AXI_awregion), .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
    .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb), .M_AXI_wlast(M_AXI_wlast),
    .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready),
    .M_AXI_bid(M_AXI_bid), .M_AXI_bresp(M_AXI_bresp), .M_AXI_bvalid(M_AXI_bvalid),
    .M_AXI_bready(M_AXI_bready)
  );

  task automatic slave_idle();
    M_AXI_awready = 1'b0;
    M_AXI_wready  = 1'b0;
    M_AXI_bvalid  = 1'b0;
    M_AXI_bresp   = 2'b00;
    M_AXI_bid     = '0;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0; wb_cyc = 1'b0; i_cnt_done = 1'b0;
    slave_idle();
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    n_chk++;
    if ({M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, wb_ack, wb_err} !== 5'b00000)
      $display("FAIL reset_ctrl got %b exp 00000", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, wb_ack, wb_err});
    else n_pass++;
    n_chk++;
    if ({M_AXI_awaddr, M_AXI_wdata, M_AXI_wstrb} !== 68'h0)
      $display("FAIL reset_regs got %h/%h/%h exp 0", M_AXI_awaddr, M_AXI_wdata, M_AXI_wstrb);
    else n_pass++;
    n_chk++;
    if ({M_AXI_awid, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst, M_AXI_awlock, M_AXI_awcache,
         M_AXI_awprot, M_AXI_awqos, M_AXI_awregion} !==
        {4'd5, 8'd0, 3'd2, 2'b01, 2'b00, 4'd0, 3'd0, 4'd0, 4'd0})
      $display("FAIL aw_constants got id=%0d len=%0d size=%0d burst=%0d exp 5/0/2/1",
               M_AXI_awid, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst);
    else n_pass++;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
  endtask

  // Idle cycles where the request is present but not qualified; nothing may issue
  task automatic idle_gap(input int ncyc, input bit allow_random);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge ACLK); #1;
      wb_adr = $urandom; wb_dat = $urandom; wb_sel = 4'($urandom);
      if (allow_random) begin
        wb_cyc = 1'($urandom);
        if ($urandom_range(0, 1) == 0) begin wb_we = 1'b1; i_cnt_done = 1'b0; end
        else begin wb_we = 1'b0; i_cnt_done = 1'($urandom); end
      end
      @(negedge ACLK);
      n_chk++;
      if ({M_AXI_awvalid, M_AXI_wvalid, wb_ack} !== 3'b000)
        $display("FAIL no_capture cyc=%0d got aw=%b w=%b ack=%b exp 000", i, M_AXI_awvalid, M_AXI_wvalid, wb_ack);
      else n_pass++;
    end
  endtask

  task automatic test_no_capture();
    @(posedge ACLK); #1;
    wb_cyc = 1'b1; wb_we = 1'b1; i_cnt_done = 1'b0;
    idle_gap(5, 1'b0);
    @(posedge ACLK); #1;
    wb_we = 1'b0; i_cnt_done = 1'b1;
    idle_gap(5, 1'b0);
    @(posedge ACLK); #1;
    wb_cyc = 1'b0; i_cnt_done = 1'b0;
  endtask

  // One write: master issues and keeps cyc high for 'hold' cycles after the ack; slave
  // accepts AW/W/B after the given number of cycles of the respective valid/ready.
  task automatic run_txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input int aw_dly, input int w_dly, input int b_dly,
                         input logic [1:0] resp, input int hold);
    bit aw_f, w_f, b_f, exp_ack, hs_aw, hs_w, hs_b;
    int aw_w, w_w, b_w, n_aw, n_w, n_ack, post, it;
    aw_f = 0; w_f = 0; b_f = 0; exp_ack = 0;
    aw_w = 0; w_w = 0; b_w = 0; n_aw = 0; n_w = 0; n_ack = 0; post = 0; it = 0;
    @(posedge ACLK); #1;
    wb_cyc = 1'b1; wb_we = 1'b1; i_cnt_done = 1'b1;
    wb_adr = adr; wb_dat = dat; wb_sel = sel;
    while (!(n_ack > 0 && post >= hold) && it < 80) begin
      @(posedge ACLK); #1;
      // Request inputs may change freely once captured
      wb_adr = $urandom; wb_dat = $urandom; wb_sel = 4'($urandom);
      M_AXI_awready = M_AXI_awvalid && (aw_w >= aw_dly);
      M_AXI_wready  = M_AXI_wvalid && (w_w >= w_dly);
      M_AXI_bvalid  = M_AXI_bready && (b_w >= b_dly);
      M_AXI_bresp   = M_AXI_bvalid ? resp : 2'b00;
      M_AXI_bid     = 4'($urandom);
      @(negedge ACLK);
      n_chk++;
      if (M_AXI_awvalid !== !aw_f) $display("FAIL awvalid it=%0d got %b exp %b", it, M_AXI_awvalid, !aw_f);
      else n_pass++;
      n_chk++;
      if (M_AXI_wvalid !== !w_f) $display("FAIL wvalid it=%0d got %b exp %b", it, M_AXI_wvalid, !w_f);
      else n_pass++;
      n_chk++;
      if (M_AXI_bready !== (aw_f && w_f && !b_f))
        $display("FAIL bready it=%0d got %b exp %b", it, M_AXI_bready, aw_f && w_f && !b_f);
      else n_pass++;
      n_chk++;
      if (wb_ack !== exp_ack) $display("FAIL wb_ack it=%0d got %b exp %b", it, wb_ack, exp_ack);
      else n_pass++;
      if (exp_ack) begin
        n_chk++;
        if (wb_err !== resp[1]) $display("FAIL wb_err got %b exp %b", wb_err, resp[1]);
        else n_pass++;
      end
      if (M_AXI_awvalid) begin
        n_chk++;
        if (M_AXI_awaddr !== adr) $display("FAIL awaddr got %h exp %h", M_AXI_awaddr, adr);
        else n_pass++;
      end
      if (M_AXI_wvalid) begin
        n_chk++;
        if ({M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast} !== {dat, sel, 1'b1})
          $display("FAIL wbeat got %h/%h/%b exp %h/%h/1", M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast, dat, sel);
        else n_pass++;
      end
      hs_aw = M_AXI_awvalid && M_AXI_awready;
      hs_w  = M_AXI_wvalid && M_AXI_wready;
      hs_b  = M_AXI_bvalid && M_AXI_bready;
      if (M_AXI_awvalid) aw_w++;
      if (M_AXI_wvalid) w_w++;
      if (M_AXI_bready) b_w++;
      n_aw += int'(hs_aw);
      n_w  += int'(hs_w);
      if (n_ack > 0) post++;
      n_ack += int'(wb_ack);
      aw_f = aw_f || hs_aw;
      w_f  = w_f || hs_w;
      b_f  = b_f || hs_b;
      exp_ack = hs_b;
      it++;
    end
    n_chk++;
    if (it >= 80) $display("FAIL txn_timeout got %0d cycles exp ack before 80", it);
    else n_pass++;
    n_chk++;
    if ({n_aw, n_w, n_ack} !== {32'd1, 32'd1, 32'd1})
      $display("FAIL txn_counts got aw=%0d w=%0d ack=%0d exp 1/1/1", n_aw, n_w, n_ack);
    else n_pass++;
    @(posedge ACLK); #1;
    wb_cyc = 1'b0; wb_we = 1'b0; i_cnt_done = 1'($urandom);
    slave_idle();
    @(negedge ACLK);
    n_chk++;
    if ({M_AXI_awvalid, M_AXI_wvalid, wb_ack} !== 3'b000)
      $display("FAIL after_release got aw=%b w=%b ack=%b exp 000", M_AXI_awvalid, M_AXI_wvalid, wb_ack);
    else n_pass++;
  endtask

  task automatic test_basic();
    run_txn(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 0);
  endtask

  task automatic test_aw_delay();
    run_txn(32'h8, 32'h12345678, 4'hF, 3, 0, 0, 2'b00, 0);
    run_txn(32'h18, 32'hA5A55A5A, 4'h6, 0, 4, 2, 2'b00, 0);
  endtask

  task automatic test_slverr();
    run_txn(32'hC, 32'hCAFEF00D, 4'h3, 0, 0, 1, 2'b10, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++)
      run_txn(32'(i * 4), $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), 0, 2'b00, 3);
  endtask

  task automatic test_reset_mid();
    @(posedge ACLK); #1;
    wb_cyc = 1'b1; wb_we = 1'b1; i_cnt_done = 1'b1;
    wb_adr = 32'h20; wb_dat = 32'h0BADF00D; wb_sel = 4'hF;
    slave_idle();
    @(posedge ACLK); #1;
    n_chk++;
    if ({M_AXI_awvalid, M_AXI_wvalid} !== 2'b11)
      $display("FAIL mid_xfer got aw=%b w=%b exp 11", M_AXI_awvalid, M_AXI_wvalid);
    else n_pass++;
    @(posedge ACLK); #1;
    ARESETN = 1'b0;
    #1;
    n_chk++;
    if ({M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, wb_ack, wb_err} !== 5'b00000)
      $display("FAIL async_reset got %b exp 00000", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, wb_ack, wb_err});
    else n_pass++;
    n_chk++;
    if ({M_AXI_awaddr, M_AXI_wdata, M_AXI_wstrb} !== 68'h0)
      $display("FAIL async_reset_regs got %h/%h/%h exp 0", M_AXI_awaddr, M_AXI_wdata, M_AXI_wstrb);
    else n_pass++;
    wb_cyc = 1'b0; wb_we = 1'b0; i_cnt_done = 1'b0;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    M_AXI_awready = 1'b1; M_AXI_wready = 1'b1; M_AXI_bvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge ACLK);
      n_chk++;
      if ({wb_ack, M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready} !== 4'b0000)
        $display("FAIL post_reset cyc=%0d got ack=%b aw=%b w=%b b=%b exp 0000",
                 i, wb_ack, M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready);
      else n_pass++;
    end
    @(posedge ACLK); #1;
    slave_idle();
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      idle_gap($urandom_range(0, 3), 1'b1);
      run_txn($urandom, $urandom, 4'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 3), 2'($urandom), $urandom_range(0, 2));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got no finish exp finish before 400000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_no_capture();
    test_basic();
    test_aw_delay();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb2axi_write.md
WB2AXI_WRITE -- requirements
Module: wb2axi_write

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (32 or 64).
REQ-003 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-004 SHALL have parameter AXI_ID, default 0, constant AWID value.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: ACLK in 1, clock; ARESETN in 1, async active-low reset.
REQ-006 SHALL have Wishbone ports: wb_adr in ADDR_WIDTH; wb_dat in DATA_WIDTH, write data; wb_sel in DATA_WIDTH/8, byte enables; wb_we in 1; wb_cyc in 1; i_cnt_done in 1, capture qualifier; wb_ack out 1; wb_err out 1.
REQ-007 SHALL have AW ports: M_AXI_awid out ID_WIDTH; awaddr out ADDR_WIDTH; awlen out 8; awsize out 3; awburst out 2; awlock out 2; awcache out 4; awprot out 3; awqos out 4; awregion out 4; awvalid out 1; awready in 1 (all prefixed M_AXI_).
REQ-008 SHALL have W ports: M_AXI_wdata out DATA_WIDTH; wstrb out DATA_WIDTH/8; wlast out 1; wvalid out 1; wready in 1.
REQ-009 SHALL have B ports: M_AXI_bid in ID_WIDTH; bresp in 2; bvalid in 1; bready out 1.

Function
REQ-010 SHALL drive constants: awid=AXI_ID, awlen=0, awsize=log2(DATA_WIDTH/8), awburst=2'b01 (INCR), awlock=0, awcache=0, awprot=0, awqos=0, awregion=0, wlast=1 whenever wvalid=1.
REQ-011 SHALL implement FSM IDLE, XFER, RESP, DONE.
REQ-012 In IDLE, when wb_cyc=1 && wb_we=1 && i_cnt_done=1 at a rising edge, SHALL register wb_adr, wb_dat, wb_sel into awaddr, wdata, wstrb and enter XFER with awvalid=1 and wvalid=1 from the next cycle (1-cycle latency).
REQ-013 With i_cnt_done=0 or wb_we=0, SHALL remain in IDLE with awvalid=wvalid=0 regardless of wb_cyc.
REQ-014 In XFER, awvalid SHALL deassert the cycle after awvalid&&awready; wvalid SHALL deassert the cycle after wvalid&&wready; the two handshakes are independent and may occur in either order or the same cycle.
REQ-015 awaddr/wdata/wstrb SHALL stay stable while the respective valid is high; valid SHALL never drop without handshake.
REQ-016 When both handshakes have completed, SHALL enter RESP the next cycle with bready=1; bready SHALL be 0 in all other states.
REQ-017 In RESP, on bvalid=1, SHALL assert wb_ack=1 for exactly one cycle (next cycle) and wb_err=bresp[1] in that same cycle, then enter DONE.
REQ-018 bid SHALL be ignored.
REQ-019 In DONE, SHALL return to IDLE when wb_cyc=0 or i_cnt_done=0; no new capture while in DONE (prevents double issue on a held request).
REQ-020 Input changes on wb_adr/wb_dat/wb_sel after capture SHALL NOT affect the outstanding transaction.
REQ-021 wb_cyc deassertion during XFER/RESP SHALL NOT abort the AXI transaction; it completes, and the ack is still generated.
REQ-022 At most one transaction SHALL be outstanding.

Reset
REQ-023 ARESETN=0 SHALL asynchronously force IDLE, awvalid=wvalid=bready=wb_ack=wb_err=0, awaddr=wdata=wstrb=0, handshake-done flags=0.
REQ-024 Reset mid-transaction SHALL abandon it; no wb_ack is produced after release.

Structure
REQ-025 AXI burst/size/cache encodings and FSM state encodings SHALL reside in shared package wb2axi_pkg, shared with the read bridge.
REQ-026 SHALL be a single module with no sub-modules.

Verification
REQ-027 wb_cyc=1, wb_we=1, i_cnt_done=0 for 5 cycles -> awvalid=wvalid=0 throughout.
REQ-028 wb_adr=0x4, wb_dat=0xDEADBEEF, wb_sel=0xF, cnt_done=1; awready=wready=1 the next cycle; bvalid=1, bresp=0 -> awaddr=0x4, wdata=0xDEADBEEF, wstrb=0xF, wlast=1, single-cycle wb_ack, wb_err=0.
REQ-029 awready delayed 3 cycles after wready -> wvalid drops after its handshake, awvalid holds 0x8 until handshake, bready only after both; one ack.
REQ-030 bresp=2'b10 (SLVERR) -> wb_ack=1 with wb_err=1 for one cycle.
REQ-031 wb_cyc and cnt_done held high after ack -> no second AW issued until wb_cyc drops; 5 back-to-back writes to 0x0,0x4,...,0x10 each produce exactly one AW, one W, one ack.
REQ-032 ARESETN pulled low while in XFER -> all valids and bready 0 immediately; no wb_ack after release.
